// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, sequencer state type and GF(2^8) helpers
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} imc_state_t;

  localparam int AES_COLS    = 4;
  localparam int AES_COL_W   = 32;
  localparam int AES_STATE_W = 128;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant as a sum of x, 2x, 4x and 8x.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// rtl/inv_mix_columns_seq_if.sv - state input and result output handshakes
interface inv_mix_columns_seq_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [0:AES_STATE_W-1] in_state;
  logic                   in_bypass;
  logic                   out_valid;
  logic                   out_ready;
  logic [0:AES_STATE_W-1] out_state;

  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state
  );

  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state
  );

endinterface

// File: rtl/inv_mix_columns_seq_word.sv
// rtl/inv_mix_columns_seq_word.sv - combinational InvMixColumns on one 32-bit column
module inv_mix_columns_seq_word
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] word,
  output logic [AES_COL_W-1:0] result
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = word;

  assign result = {
    gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
    gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
    gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
    gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
  };

endmodule

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - one column per clock through a shared InvMixColumns unit
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset_n,
  inv_mix_columns_seq_if.slave  bus,
  output logic                  busy
);

  imc_state_t             fsm, fsm_next;
  logic [1:0]             col, col_next;
  logic [0:AES_STATE_W-1] state_reg, state_reg_next;
  logic                   out_valid_q, out_valid_next;
  logic [AES_COLS-1:0]    col_en;
  logic [AES_COL_W-1:0]   mux_word, unit_word;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm         <= IDLE;
      col         <= 2'd0;
      state_reg   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm         <= fsm_next;
      col         <= col_next;
      state_reg   <= state_reg_next;
      out_valid_q <= out_valid_next;
    end
  end

  always_comb begin
    mux_word = '0;
    for (int c = 0; c < AES_COLS; c++) begin
      if (col == c[1:0]) mux_word = state_reg[c*AES_COL_W +: AES_COL_W];
    end
  end

  inv_mix_columns_seq_word u_word (
    .word   (mux_word),
    .result (unit_word)
  );

  always_comb begin
    fsm_next       = fsm;
    col_next       = col;
    state_reg_next = state_reg;
    out_valid_next = out_valid_q;
    col_en         = '0;
    unique case (fsm)
      IDLE: begin
        if (bus.in_valid) begin
          state_reg_next = bus.in_state;
          col_next       = 2'd0;
          fsm_next       = bus.in_bypass ? DONE : RUN;
        end
      end
      RUN: begin
        col_en   = 4'b0001 << col;
        col_next = col + 2'd1;
        for (int c = 0; c < AES_COLS; c++) begin
          if (col_en[c]) state_reg_next[c*AES_COL_W +: AES_COL_W] = unit_word;
        end
        if (col == 2'd3) begin
          fsm_next       = DONE;
          out_valid_next = 1'b1;
        end
      end
      DONE: begin
        // A bypassed state spends one cycle here before out_valid rises.
        if (out_valid_q && bus.out_ready) begin
          fsm_next       = IDLE;
          out_valid_next = 1'b0;
        end else begin
          out_valid_next = 1'b1;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (fsm == IDLE);
    bus.out_valid = out_valid_q;
    bus.out_state = state_reg;
    busy          = (fsm != IDLE);
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - directed and streamed checks of the column sequencer
module tb_inv_mix_columns_seq;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic busy;
  int   n_pass = 0;
  int   n_checks = 0;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101;
  localparam logic [127:0] VB = 128'h00112233_44556677_8899aabb_ccddeeff;

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns: undoing the DUT result must recover the input.
  function automatic logic [127:0] mix_fwd(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  task automatic send(input logic [127:0] st, input logic byp, output logic ok);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge Clk);
      t++;
    end
    ok = bus.in_ready;
    bus.in_valid  = 1'b1;
    bus.in_state  = st;
    bus.in_bypass = byp;
    @(negedge Clk);
    bus.in_valid  = 1'b0;
    bus.in_bypass = 1'b0;
  endtask

  task automatic wait_out(output logic [127:0] got, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    got = bus.out_state;
  endtask

  task automatic do_vec(input string tag, input logic [127:0] st, input logic byp,
                        input logic [127:0] exp, input int exp_lat);
    logic         ok;
    logic [127:0] got;
    int           lat;
    bus.out_ready = 1'b1;
    send(st, byp, ok);
    check({tag, "_accept"}, 128'(ok), 128'd1);
    check({tag, "_busy"}, 128'(busy), 128'd1);
    check({tag, "_in_ready_low"}, 128'(bus.in_ready), 128'd0);
    wait_out(got, lat);
    check({tag, "_state"}, got, exp);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    @(negedge Clk);
    check({tag, "_hs_in_ready"}, 128'(bus.in_ready), 128'd1);
    check({tag, "_hs_out_valid"}, 128'(bus.out_valid), 128'd0);
  endtask

  initial begin
    logic         ok, seen;
    logic [127:0] got, st;
    logic         byp;
    int           lat;

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_state", bus.out_state, 128'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    do_vec("vec1", V1, 1'b0, E1, 4);
    do_vec("vec2", V2, 1'b0, E2, 4);
    do_vec("bypass", VB, 1'b1, VB, 1);
    check("bypass_col", 128'(dut.col), 128'd0);

    // Backpressure with an ignored input pulse while DONE.
    bus.out_ready = 1'b0;
    send(V1, 1'b0, ok);
    check("bp_accept", 128'(ok), 128'd1);
    wait_out(got, lat);
    check("bp_latency", 128'(lat), 128'd4);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      check("bp_out_state", bus.out_state, E1);
      bus.in_valid = (i == 3);
      bus.in_state = V2;
      @(negedge Clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge Clk);
    check("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
    check("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      seen = seen | bus.out_valid;
    end
    check("bp_pulse_ignored", 128'(seen), 128'd0);

    // Asynchronous reset after column 1 has been written.
    send(V1, 1'b0, ok);
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(bus.out_valid), 128'd0);
    check("arst_in_ready", 128'(bus.in_ready), 128'd1);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_out_state", bus.out_state, 128'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    do_vec("post_rst", V2, 1'b0, E2, 4);

    // Stream of random states, random bypass and random consumer stalls.
    for (int i = 0; i < 8; i++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      byp = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      bus.out_ready = 1'b0;
      send(st, byp, ok);
      check("stream_accept", 128'(ok), 128'd1);
      wait_out(got, lat);
      check("stream_latency", 128'(lat), byp ? 128'd1 : 128'd4);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      bus.out_ready = 1'b1;
      got = bus.out_state;
      @(negedge Clk);
      bus.out_ready = 1'b0;
      if (byp) check("stream_bypass", got, st);
      else     check("stream_mix", mix_fwd(got), st);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Iterative sequencer that time-shares a single 32-bit InvMixColumns word unit across the four columns of a 128-bit AES state. Sits in the AES decryption round datapath between InvSubBytes/AddRoundKey and the round-state register. Accepts one state per valid/ready handshake, processes one column per clock, and returns the transformed state, or the unmodified state in bypass mode for the final round.

## Interface
- No parameters; widths fixed by AES: 128-bit state, 32-bit column, 4 columns.
- Clk  input  1  sole clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_state/in_bypass valid.
- in_ready  output  1  block can accept a state; reset 1.
- in_state  input  [0:127]  big-endian state; column c = bits [32c : 32c+31].
- in_bypass  input  1  1 = pass state through unchanged (last decryption round).
- out_valid  output  1  out_state valid; reset 0.
- out_ready  input  1  consumer accepts out_state.
- out_state  output  [0:127]  result; reset 128'h0.
- busy  output  1  state != IDLE; reset 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE, clears col counter (2 bits), state register, out_valid.
- IDLE: in_ready=1. On in_valid: load in_state into internal state register; if in_bypass go to DONE, else col=0 and go to RUN.
- RUN: in_ready=0. Each cycle, word unit input = state_reg column col; its output overwrites the same column in state_reg; col increments. When col==3 is written, go to DONE; col wraps to 0.
- DONE: out_valid=1, out_state=state_reg, in_ready=0. Hold until out_ready; on out_valid&&out_ready go to IDLE.
- out_state is driven from state_reg directly and is stable while out_valid=1 and out_ready=0.
- in_valid while not in IDLE is ignored. No back-to-back overlap: the next accept is earliest the cycle after the output handshake.
- Reset_n low in any state (mid-RUN included) aborts immediately. Partial columns are discarded and all outputs return to their reset values asynchronously.
- Bypass skips the word unit entirely; state is passed bit-exact.

## Timing
- Accept at rising edge k (in_valid&&in_ready).
- Normal path: columns 0..3 written at edges k+1..k+4; out_valid high after edge k+4. Latency 4 cycles.
- Bypass path: out_valid high after edge k+1. Latency 1 cycle.
- Output handshake at edge m: out_valid low and in_ready high after edge m.
- Throughput with out_ready tied high: normal one state per 6 cycles; bypass one state per 3 cycles.
- busy is high exactly while in RUN or DONE.

## Structure
- Shared package aes_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} imc_state_t; constants AES_COLS=4, AES_COL_W=32, AES_STATE_W=128.
- One sub-module instance: the existing 32-bit InvMixColumns word module, fed by a 4:1 column mux driven by col. Its output is written back via a column-enable decode.
- All registers use a single always_ff on posedge Clk or negedge Reset_n. Next-state logic is in always_comb.

## Test plan
- Single column vector: in_state = {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}, in_bypass=0, out_ready=1. Required: out_state = {db135345, f20a225c, 01010101, c6c6c6c6}, with out_valid exactly 4 cycles after the accept edge.
- Second vector: {d5d5d7d6, 4d7ebdf8, c6c6c6c6, 01010101} produces {d4d4d4d5, 2d26314c, c6c6c6c6, 01010101}.
- Bypass: in_state = 00112233_44556677_8899aabb_ccddeeff with in_bypass=1. out_state is identical; out_valid 1 cycle after accept; the word unit column mux never advances.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_valid and out_state are stable and in_ready=0. A second in_valid pulse is ignored. After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-operation: assert Reset_n=0 asynchronously after column 1 is written. out_valid=0, in_ready=1, busy=0, out_state=0 without a clock edge. A fresh vector after release gives correct results.
- Back-to-back stream: 8 random states with random in_bypass and random out_ready stalls. Compare against the golden model, in order and with no drops.
